// File: rtl/ysyx_22041071_axi_rd_arb.sv
// Read-request arbiter sharing one AXI read-channel master between IF and MEM.
// Ports: clk/reset; if_*/mem_* request + return-beat sets; dn_ar_*/dn_r_* to the
// read master; busy_o while a transaction is in flight; len_err_o burst-length pulse.
`timescale 1ns/1ps
module ysyx_22041071_axi_rd_arb #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [LEN_W-1:0]  if_len_i,
    input  logic [1:0]        if_size_i,
    output logic              if_ack_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic [1:0]        if_rresp_o,
    output logic              if_rlast_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LEN_W-1:0]  mem_len_i,
    input  logic [1:0]        mem_size_i,
    output logic              mem_ack_o,
    output logic              mem_rvalid_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [1:0]        mem_rresp_o,
    output logic              mem_rlast_o,
    output logic              dn_ar_valid_o,
    input  logic              dn_ar_ready_i,
    output logic [3:0]        dn_id_o,
    output logic [ADDR_W-1:0] dn_addr_o,
    output logic [LEN_W-1:0]  dn_len_o,
    output logic [1:0]        dn_size_o,
    output logic              dn_r_ready_o,
    input  logic              dn_r_valid_i,
    input  logic [DATA_W-1:0] dn_r_data_i,
    input  logic [1:0]        dn_r_resp_i,
    input  logic              dn_r_last_i,
    output logic              busy_o,
    output logic              len_err_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    state_t            state;
    logic [2:0]        starve_cnt;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              owner_q;
    logic              len_err_q;

    logic if_wins;
    logic in_idle;
    logic in_data;
    logic if_sel;
    logic mem_sel;
    logic hit_len;
    logic beat_bad;

    // MEM has priority unless IF has lost STARVE_MAX times in a row.
    assign if_wins = if_req_i & (~mem_req_i | (starve_cnt == SMAX));

    // Combinational outputs are masked by reset so nothing leaks out
    // during the cycle in which a synchronous reset is being applied.
    assign in_idle = (state == IDLE) & ~reset;
    assign in_data = (state == DATA) & ~reset;
    assign if_sel  = in_data & ~owner_q;
    assign mem_sel = in_data & owner_q;

    // beat_cnt counts beats already accepted; the final beat of a
    // burst of len+1 beats arrives while beat_cnt == len.
    assign hit_len  = (beat_cnt == len_q);
    assign beat_bad = dn_r_last_i ? ~hit_len : hit_len;

    assign if_ack_o  = in_idle & if_wins;
    assign mem_ack_o = in_idle & mem_req_i & ~if_wins;

    assign dn_ar_valid_o = (state == ADDR) & ~reset;
    assign dn_id_o       = {3'b000, owner_q};
    assign dn_addr_o     = addr_q;
    assign dn_len_o      = len_q;
    assign dn_size_o     = size_q;
    assign dn_r_ready_o  = in_data;

    assign if_rvalid_o = if_sel & dn_r_valid_i;
    assign if_rdata_o  = if_sel ? dn_r_data_i : '0;
    assign if_rresp_o  = if_sel ? dn_r_resp_i : 2'b00;
    assign if_rlast_o  = if_sel & dn_r_valid_i & dn_r_last_i;

    assign mem_rvalid_o = mem_sel & dn_r_valid_i;
    assign mem_rdata_o  = mem_sel ? dn_r_data_i : '0;
    assign mem_rresp_o  = mem_sel ? dn_r_resp_i : 2'b00;
    assign mem_rlast_o  = mem_sel & dn_r_valid_i & dn_r_last_i;

    assign busy_o    = (state != IDLE);
    assign len_err_o = len_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            beat_cnt   <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            size_q     <= 2'b00;
            owner_q    <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            len_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req_i | mem_req_i) begin
                        owner_q <= ~if_wins;
                        addr_q  <= if_wins ? if_addr_i : mem_addr_i;
                        len_q   <= if_wins ? if_len_i  : mem_len_i;
                        size_q  <= if_wins ? if_size_i : mem_size_i;
                        state   <= ADDR;
                        if (if_wins) begin
                            starve_cnt <= 3'd0;
                        end else if (if_req_i && starve_cnt != SMAX) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                    end
                end
                ADDR: begin
                    if (dn_ar_ready_i) begin
                        state    <= DATA;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (dn_r_valid_i) begin
                        beat_cnt  <= beat_cnt + LEN_W'(1);
                        len_err_q <= beat_bad;
                        if (dn_r_last_i) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_axi_rd_arb.sv
// Scoreboard bench for ysyx_22041071_axi_rd_arb: directed scenarios then random traffic.
// Requester and read-master models drive the DUT; a negedge monitor checks against a model.
`timescale 1ns/1ps
module tb_ysyx_22041071_axi_rd_arb;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 8;
    localparam int SMAX = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0]    size;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          if_req_i, mem_req_i;
    logic [AW-1:0] if_addr_i, mem_addr_i;
    logic [LW-1:0] if_len_i, mem_len_i;
    logic [1:0]    if_size_i, mem_size_i;
    logic          if_ack_o, mem_ack_o;
    logic          if_rvalid_o, mem_rvalid_o;
    logic [DW-1:0] if_rdata_o, mem_rdata_o;
    logic [1:0]    if_rresp_o, mem_rresp_o;
    logic          if_rlast_o, mem_rlast_o;
    logic          dn_ar_valid_o, dn_ar_ready_i;
    logic [3:0]    dn_id_o;
    logic [AW-1:0] dn_addr_o;
    logic [LW-1:0] dn_len_o;
    logic [1:0]    dn_size_o;
    logic          dn_r_ready_o, dn_r_valid_i, dn_r_last_i;
    logic [DW-1:0] dn_r_data_i;
    logic [1:0]    dn_r_resp_i;
    logic          busy_o, len_err_o;

    ysyx_22041071_axi_rd_arb #(
        .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_len_i(if_len_i), .if_size_i(if_size_i),
        .if_ack_o(if_ack_o), .if_rvalid_o(if_rvalid_o),
        .if_rdata_o(if_rdata_o), .if_rresp_o(if_rresp_o),
        .if_rlast_o(if_rlast_o),
        .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_len_i(mem_len_i), .mem_size_i(mem_size_i),
        .mem_ack_o(mem_ack_o), .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o(mem_rdata_o), .mem_rresp_o(mem_rresp_o),
        .mem_rlast_o(mem_rlast_o),
        .dn_ar_valid_o(dn_ar_valid_o), .dn_ar_ready_i(dn_ar_ready_i),
        .dn_id_o(dn_id_o), .dn_addr_o(dn_addr_o),
        .dn_len_o(dn_len_o), .dn_size_o(dn_size_o),
        .dn_r_ready_o(dn_r_ready_o), .dn_r_valid_i(dn_r_valid_i),
        .dn_r_data_i(dn_r_data_i), .dn_r_resp_i(dn_r_resp_i),
        .dn_r_last_i(dn_r_last_i),
        .busy_o(busy_o), .len_err_o(len_err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // stimulus queues: pending (to be issued) and issued-awaiting-grant
    req_t if_pend[$], mem_pend[$];
    req_t if_exp[$], mem_exp[$];

    // configuration of the read-master model
    int          cfg_ar_wait = 0;
    int          cfg_last_at = 0;
    bit          cfg_gap = 0;
    bit          cfg_stray = 0;
    bit          cfg_fixed = 0;
    logic [63:0] cfg_data = '0;

    // monitor-owned event flags and counters
    bit ev_if_ack = 0, ev_mem_ack = 0, ev_ar_hs = 0;
    logic [LW-1:0] ev_ar_len = '0;
    int n_if_ack = 0, n_mem_ack = 0, n_if_rv = 0, n_mem_rv = 0, n_err = 0;
    logic [DW-1:0] last_if_data = '0;
    bit hist[$];

    // model of the transaction in progress
    int   phase = 0;
    int   m_starve = 0;
    int   m_bidx = 0;
    int   m_len = 0;
    bit   m_owner = 0;
    bit   exp_err = 0;
    bit   w_if, exp_ifv, exp_memv;
    req_t cur;

    bit dn_sending = 0;

    function automatic req_t rnd_req();
        req_t r;
        r.addr = {$urandom, $urandom};
        r.len  = LW'($urandom_range(0, 3));
        r.size = 2'($urandom_range(0, 3));
        return r;
    endfunction

    initial begin : req_drv
        req_t r;
        if_req_i = 0; if_addr_i = '0; if_len_i = '0; if_size_i = '0;
        mem_req_i = 0; mem_addr_i = '0; mem_len_i = '0; mem_size_i = '0;
        forever begin
            @(posedge clk); #1;
            if (ev_if_ack) if_req_i = 0;
            if (ev_mem_ack) mem_req_i = 0;
            if (!if_req_i && if_pend.size() > 0) begin
                r = if_pend.pop_front();
                if_req_i = 1; if_addr_i = r.addr;
                if_len_i = r.len; if_size_i = r.size;
                if_exp.push_back(r);
            end
            if (!mem_req_i && mem_pend.size() > 0) begin
                r = mem_pend.pop_front();
                mem_req_i = 1; mem_addr_i = r.addr;
                mem_len_i = r.len; mem_size_i = r.size;
                mem_exp.push_back(r);
            end
        end
    end

    initial begin : dn_drv
        int wait_cnt, tw, nb, bidx;
        bit drove, drove_last;
        wait_cnt = 0; tw = 0; nb = 1; bidx = 0;
        drove = 0; drove_last = 0;
        dn_ar_ready_i = 0; dn_r_valid_i = 0; dn_r_last_i = 0;
        dn_r_data_i = '0; dn_r_resp_i = '0;
        forever begin
            @(posedge clk); #1;
            if (drove) begin
                bidx++;
                if (drove_last) dn_sending = 0;
            end
            if (ev_ar_hs) begin
                dn_sending = 1; bidx = 0;
                if (cfg_last_at > 0) nb = cfg_last_at;
                else if (cfg_last_at < 0 && $urandom_range(0, 3) == 0)
                    nb = $urandom_range(1, int'(ev_ar_len) + 2);
                else nb = int'(ev_ar_len) + 1;
            end
            if (dn_ar_valid_o) begin
                if (wait_cnt == 0)
                    tw = (cfg_ar_wait >= 0) ? cfg_ar_wait : $urandom_range(0, 3);
                dn_ar_ready_i = (wait_cnt >= tw);
                wait_cnt++;
            end else begin
                dn_ar_ready_i = cfg_stray ? 1'($urandom_range(0, 1)) : 1'b0;
                wait_cnt = 0;
            end
            drove = 0; drove_last = 0;
            if (dn_sending && !(cfg_gap && $urandom_range(0, 3) == 0)) begin
                dn_r_valid_i = 1;
                dn_r_data_i = cfg_fixed ? cfg_data : {$urandom, $urandom};
                dn_r_resp_i = 2'($urandom_range(0, 3));
                dn_r_last_i = (bidx + 1 == nb);
                drove = 1; drove_last = dn_r_last_i;
            end else if (!dn_sending && cfg_stray && $urandom_range(0, 5) == 0) begin
                dn_r_valid_i = 1;
                dn_r_data_i = {$urandom, $urandom};
                dn_r_last_i = 1'($urandom_range(0, 1));
            end else begin
                dn_r_valid_i = 0; dn_r_last_i = 0;
            end
        end
    end

    always @(negedge clk) begin
        ev_if_ack  = if_ack_o;
        ev_mem_ack = mem_ack_o;
        ev_ar_hs   = dn_ar_valid_o && dn_ar_ready_i;
        ev_ar_len  = dn_len_o;
        if (if_ack_o) begin hist.push_back(1'b0); n_if_ack++; end
        if (mem_ack_o) begin hist.push_back(1'b1); n_mem_ack++; end
        if (if_rvalid_o) begin n_if_rv++; last_if_data = if_rdata_o; end
        if (mem_rvalid_o) n_mem_rv++;
        if (reset) begin
            check("rst_comb", {if_ack_o, mem_ack_o, dn_ar_valid_o,
                  dn_r_ready_o, if_rvalid_o, mem_rvalid_o}, 0);
            phase = 0; m_starve = 0; exp_err = 0;
        end else begin
            if (len_err_o) n_err++;
            check("len_err", len_err_o, exp_err);
            exp_err = 0;
            check("busy", busy_o, phase != 0);
            check("ar_valid", dn_ar_valid_o, phase == 1);
            check("r_ready", dn_r_ready_o, phase == 2);
            exp_ifv  = (phase == 2) && dn_r_valid_i && !m_owner;
            exp_memv = (phase == 2) && dn_r_valid_i && m_owner;
            check("rvalid", {if_rvalid_o, mem_rvalid_o}, {exp_ifv, exp_memv});
            if (exp_ifv)
                check("if_beat", {if_rdata_o, if_rresp_o, if_rlast_o},
                      {dn_r_data_i, dn_r_resp_i, dn_r_last_i});
            if (exp_memv)
                check("mem_beat", {mem_rdata_o, mem_rresp_o, mem_rlast_o},
                      {dn_r_data_i, dn_r_resp_i, dn_r_last_i});
            if (phase == 0 && (if_req_i || mem_req_i)) begin
                w_if = if_req_i && (!mem_req_i || m_starve == SMAX);
                check("ack", {if_ack_o, mem_ack_o}, {w_if, !w_if});
                check("exp_q", (w_if ? if_exp.size() : mem_exp.size()) != 0, 1);
                if (w_if && if_exp.size() > 0) cur = if_exp.pop_front();
                if (!w_if && mem_exp.size() > 0) cur = mem_exp.pop_front();
                if (w_if) m_starve = 0;
                else if (if_req_i && m_starve < SMAX) m_starve++;
                m_owner = !w_if;
                m_len = int'(cur.len);
                phase = 1;
            end else begin
                check("no_ack", {if_ack_o, mem_ack_o}, 0);
                if (phase == 1) begin
                    check("ar_fields", {dn_id_o, dn_addr_o, dn_len_o, dn_size_o},
                          {4'(m_owner), cur.addr, cur.len, cur.size});
                    if (dn_ar_ready_i) begin phase = 2; m_bidx = 0; end
                end else if (phase == 2 && dn_r_valid_i) begin
                    exp_err = dn_r_last_i ? (m_bidx != m_len) : (m_bidx == m_len);
                    m_bidx++;
                    if (dn_r_last_i) phase = 0;
                end
            end
        end
    end

    task automatic wait_quiet(input int budget, input string nm);
        int n = 0;
        while (n < budget && !(if_pend.size() == 0 && mem_pend.size() == 0 &&
               !if_req_i && !mem_req_i && phase == 0 && !dn_sending)) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_timeout"}, n >= budget, 0);
        repeat (2) @(posedge clk);
    endtask

    function automatic req_t mk(input logic [63:0] a, input int l, input int s);
        req_t r;
        r.addr = a; r.len = LW'(l); r.size = 2'(s);
        return r;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        int b_ia, b_ma, b_ir, b_mr, b_er, h0, n, pushed;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_state", {busy_o, len_err_o, dn_id_o, dn_addr_o, dn_len_o,
              dn_size_o, if_ack_o, mem_ack_o}, 0);
        @(posedge clk);

        // single IF read, master ready after 2 cycles
        cfg_ar_wait = 2; cfg_fixed = 1; cfg_data = 64'hDEAD_BEEF;
        b_ia = n_if_ack; b_ir = n_if_rv; b_mr = n_mem_rv; b_er = n_err;
        if_pend.push_back(mk(64'h8000_0000, 0, 3));
        wait_quiet(100, "s1");
        check("s1_if_ack", n_if_ack - b_ia, 1);
        check("s1_if_rv", n_if_rv - b_ir, 1);
        check("s1_mem_rv", n_mem_rv - b_mr, 0);
        check("s1_data", last_if_data, 64'hDEAD_BEEF);
        check("s1_err", n_err - b_er, 0);
        cfg_fixed = 0; cfg_ar_wait = 0;

        // simultaneous requests: MEM first, then IF
        h0 = hist.size();
        if_pend.push_back(rnd_req());
        mem_pend.push_back(rnd_req());
        wait_quiet(200, "s2");
        check("s2_n", hist.size() - h0, 2);
        if (hist.size() - h0 == 2)
            check("s2_order", {hist[h0], hist[h0+1]}, 2'b10);

        // IF starved by continuous MEM: wins on the 5th arbitration
        h0 = hist.size();
        if_pend.push_back(rnd_req());
        for (int i = 0; i < 6; i++) mem_pend.push_back(rnd_req());
        wait_quiet(500, "s3");
        check("s3_n", hist.size() - h0, 7);
        if (hist.size() - h0 == 7)
            for (int i = 0; i < 7; i++)
                check($sformatf("s3_win%0d", i), hist[h0+i], i != 4);
        h0 = hist.size();
        if_pend.push_back(rnd_req());
        mem_pend.push_back(rnd_req());
        wait_quiet(200, "s3b");
        if (hist.size() - h0 == 2)
            check("s3_starve_clr", {hist[h0], hist[h0+1]}, 2'b10);

        // MEM burst len=3: correct last, then last on beat 2
        b_ir = n_if_rv; b_mr = n_mem_rv; b_er = n_err;
        mem_pend.push_back(mk({$urandom, $urandom}, 3, 3));
        wait_quiet(200, "s4a");
        check("s4a_mem_rv", n_mem_rv - b_mr, 4);
        check("s4a_if_rv", n_if_rv - b_ir, 0);
        check("s4a_err", n_err - b_er, 0);
        cfg_last_at = 2;
        b_mr = n_mem_rv; b_er = n_err;
        mem_pend.push_back(mk({$urandom, $urandom}, 3, 2));
        wait_quiet(200, "s4b");
        check("s4b_mem_rv", n_mem_rv - b_mr, 2);
        check("s4b_err", n_err - b_er, 1);
        cfg_last_at = 0;

        // master stalls AR for 10 cycles; second MEM request must wait
        cfg_ar_wait = 10;
        b_ma = n_mem_ack;
        mem_pend.push_back(rnd_req());
        repeat (4) @(posedge clk);
        mem_pend.push_back(rnd_req());
        repeat (6) @(posedge clk);
        check("s5_held", n_mem_ack - b_ma, 1);
        wait_quiet(300, "s5");
        check("s5_total", n_mem_ack - b_ma, 2);
        cfg_ar_wait = 0;

        // reset in DATA after the first of four beats
        b_mr = n_mem_rv; b_er = n_err;
        mem_pend.push_back(mk({$urandom, $urandom}, 3, 1));
        n = 0;
        while (n_mem_rv - b_mr < 1 && n < 100) begin @(posedge clk); n++; end
        check("s6_timeout", n >= 100, 0);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("s6_outs", {busy_o, len_err_o, dn_r_ready_o, dn_ar_valid_o,
              mem_rvalid_o, if_rvalid_o, dn_id_o, dn_addr_o, dn_len_o,
              dn_size_o}, 0);
        check("s6_rdata", {mem_rdata_o, if_rdata_o}, 0);
        wait_quiet(100, "s6");
        check("s6_mem_rv", n_mem_rv - b_mr, 1);
        check("s6_err", n_err - b_er, 0);

        // random traffic
        cfg_ar_wait = -1; cfg_last_at = -1;
        cfg_gap = 1; cfg_stray = 1;
        b_ia = n_if_ack; b_ma = n_mem_ack; pushed = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            if ($urandom_range(0, 7) == 0 && if_pend.size() < 2) begin
                if_pend.push_back(rnd_req()); pushed++;
            end
            if ($urandom_range(0, 3) == 0 && mem_pend.size() < 2) begin
                mem_pend.push_back(rnd_req()); pushed++;
            end
        end
        wait_quiet(5000, "rand");
        check("rand_grants", (n_if_ack - b_ia) + (n_mem_ack - b_ma), pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_axi_rd_arb.md
YSYX_22041071_AXI_RD_ARB -- requirements
Module: ysyx_22041071_axi_rd_arb

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
  - ADDR_W, 64, address width.
  - DATA_W, 64, data width.
  - LEN_W, 8, burst length width.
  - STARVE_MAX, 4, consecutive IF losses before IF is forced to win.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
  - clk, in, 1, single clock; all state updates on its rising edge.
  - reset, in, 1, synchronous, active-high reset.
  - if_req_i, in, 1, instruction-fetch read request.
  - if_addr_i / if_len_i / if_size_i, in, ADDR_W / LEN_W / 2, IF request fields.
  - if_ack_o, out, 1, one-cycle request-accepted pulse to IF.
  - if_rvalid_o / if_rdata_o / if_rresp_o / if_rlast_o, out, 1 / DATA_W / 2 / 1, IF return beat.
  - mem_req_i, mem_addr_i, mem_len_i, mem_size_i, mem_ack_o, mem_rvalid_o, mem_rdata_o, mem_rresp_o, mem_rlast_o: same as the IF set, for the load/store unit.
  - dn_ar_valid_o, out, 1, request to the AXI read-channel master.
  - dn_ar_ready_i, in, 1, read master accepts the request.
  - dn_id_o / dn_addr_o / dn_len_o / dn_size_o, out, 4 / ADDR_W / LEN_W / 2, request fields; id 0 = IF, 1 = MEM.
  - dn_r_ready_o, out, 1, arbiter accepts a return beat.
  - dn_r_valid_i / dn_r_data_i / dn_r_resp_i / dn_r_last_i, in, 1 / DATA_W / 2 / 1, return beat.
  - busy_o, out, 1, a transaction is in flight.
  - len_err_o, out, 1, one-cycle pulse on a burst-length mismatch.

Function
REQ-003 The state machine SHALL have three states: IDLE, ADDR and DATA.
REQ-004 In IDLE, when at least one request is present, the arbiter SHALL select a winner, pulse that requester's ack for exactly this cycle, latch the winner's addr/len/size and owner into registers, and move to ADDR on the next edge.
REQ-005 The arbitration rule SHALL be:
  - MEM wins over IF by default.
  - If starve_cnt equals STARVE_MAX and if_req_i is high, IF wins.
REQ-006 starve_cnt SHALL behave as follows:
  - It is LEN_W-independent, 3 bits wide.
  - It increments, saturating at STARVE_MAX, each time IF requests in IDLE and loses.
  - It clears when IF wins.
  - It is unchanged otherwise.
REQ-007 In ADDR, dn_ar_valid_o SHALL be 1 and dn_id_o/addr/len/size SHALL be driven from the latched registers and held stable until dn_ar_ready_i; on ar_valid and ar_ready the state SHALL move to DATA and beat_cnt SHALL clear to 0.
REQ-008 In DATA, dn_r_ready_o SHALL be 1 and each beat SHALL be routed combinationally (zero latency) to the owner's rvalid/rdata/rresp/rlast; the non-owner's rvalid SHALL stay 0.
REQ-009 On each accepted beat, beat_cnt SHALL increment.
REQ-010 On an accepted beat with dn_r_last_i=1, the state SHALL return to IDLE.
REQ-011 len_err_o SHALL pulse when last arrives with beat_cnt != latched len, or when beat_cnt equals the latched len without last; in the second case the state SHALL stay in DATA until last.
REQ-012 No ack SHALL be issued outside IDLE; requests held during ADDR/DATA SHALL wait, and the arbiter SHALL re-arbitrate in IDLE one cycle after the DATA-to-IDLE transition (no back-to-back issue in the same cycle).
REQ-013 Simultaneous requests in IDLE SHALL produce exactly one ack.
REQ-014 dn_r_ready_o SHALL be 0 in IDLE and ADDR; return beats are not expected there and SHALL NOT be forwarded.
REQ-015 busy_o SHALL equal (state != IDLE).
REQ-016 Fields SHALL be passed unmodified; the arbiter performs no address alignment.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL set state=IDLE, starve_cnt=0, beat_cnt=0, all latched fields=0, and every registered output=0; combinational outputs SHALL then evaluate to 0.
REQ-018 Reset asserted during ADDR or DATA SHALL abandon the transaction with no ack, rvalid or len_err, and no beat SHALL be forwarded after reset.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
  - Single IF request, addr=0x8000_0000, len=0; downstream ready after 2 cycles, one beat 0xDEAD_BEEF with last -> if_ack 1 cycle, dn_id_o=0, if_rdata=0xDEAD_BEEF with if_rlast=1, busy low the next cycle.
  - IF and MEM request in the same cycle, starve_cnt=0 -> mem_ack only, dn_id_o=1; IF acked in the IDLE after MEM completes.
  - MEM requesting continuously with IF held for 5 arbitrations -> MEM wins 4 times, IF wins the 5th, starve_cnt returns to 0.
  - MEM burst len=3 with 4 beats, last on the 4th -> 4 mem_rvalid pulses, if_rvalid never set, len_err_o stays 0; repeat with last on the 2nd beat -> len_err_o pulses once, state returns to IDLE.
  - dn_ar_ready_i held low for 10 cycles -> dn_ar_valid_o and fields remain stable throughout; a new MEM request arriving meanwhile gets no ack.
  - reset asserted during DATA after 1 of 4 beats -> next cycle all outputs 0, state IDLE; further beats ignored, dn_r_ready_o=0.
